stream_state_accum: RTL
=======================

// Module: stream_state_accum
// PURPOSE
//   Parametrised multi-channel state accumulator: successor of the 1-bit toggle state machine
//   (out = current state, next = in ^ state, always continuing). Generalises it to NCH channels
//   of W-bit state with XOR/ADD/LOAD modes and a terminating FINISH command.
//   Sits between an input stream source and consumers needing per-channel running state.
//   Defaults (W=1, NCH=1, XOR mode) reproduce the original block cycle-for-cycle.
// PARAMETERS
//   W     1  state/data width per channel (>=1)
//   NCH   1  number of channels (>=1); CHW = (NCH>1) ? $clog2(NCH) : 1
//   INIT  0  reset/initial value of every channel state (W bits)
//   CW    8  width of saturating update counter
// PORTS
//   clk       in   1    clock, all state updates on rising edge
//   rst       in   1    asynchronous reset, active-high
//   in_valid  in   1    command valid
//   in_ready  out  1    high while FSM in RUN; commands accepted when in_valid & in_ready
//   in_ch     in   CHW  target channel
//   in_mode   in   2    00 XOR, 01 ADD, 10 LOAD, 11 FINISH
//   in_data   in   W    operand
//   out_data  out  W    pre-update state of channel in_ch (combinational from state regs + in_ch)
//   cont      out  1    1 = running, 0 = terminated (registered, = ~done)
//   done      out  1    registered, set on accepted FINISH, sticky until reset
//   err       out  1    registered one-cycle pulse: accepted command with in_ch >= NCH
//   upd_cnt   out  CW   registered count of accepted state-changing commands, saturates at all-ones
// BEHAVIOUR
//   Reset (async, rst=1): st[i]=INIT for all i; FSM=RUN; done=0; cont=1; err=0; upd_cnt=0;
//     in_ready=1; out_data=st[in_ch] -> INIT. Reset mid-operation discards everything immediately.
//   Accept = in_valid & in_ready. No accept -> all state holds, err=0 next cycle.
//   out_data never depends on in_data or in_mode (no comb path); in_ch >= NCH -> out_data=0.
//   On accept, ch valid (in_ch < NCH), next edge:
//     XOR : st[ch] <= st[ch] ^ in_data
//     ADD : st[ch] <= (st[ch] + in_data) mod 2^W (carry discarded)
//     LOAD: st[ch] <= in_data
//     upd_cnt <= upd_cnt+1 unless all-ones (XOR/ADD/LOAD count even if value unchanged).
//   FINISH (accepted, any in_ch incl. invalid): FSM RUN->DONE; done<=1, cont<=0; no st change;
//     upd_cnt unchanged; err not raised by FINISH.
//   Invalid channel on XOR/ADD/LOAD: no st change, no count, err<=1 for exactly one cycle.
//   Other channels never change when one channel is updated.
//   FSM: RUN --accepted FINISH--> DONE; DONE --rst--> RUN only. In DONE: in_ready=0, commands
//     ignored, st/upd_cnt frozen, out_data still reads st[in_ch].
//   Latency: command at edge k visible on out_data/upd_cnt/done/err after edge k (next cycle).
//   Back-to-back accepts on same channel every cycle legal; each sees prior update.
//   W=1: ADD and XOR are identical (mod 2).
// TESTING
//   1. Defaults, in_valid=1, XOR, in_data 1,1,0,1 -> out_data 0,1,0,0; st afterwards 1; upd_cnt=4.
//   2. W=8,NCH=4: ADD ch2 0xF0, then ADD ch2 0x20 -> out_data(ch2) 0x00,0xF0, then 0x10 (wrap);
//      ch0,ch1,ch3 remain INIT.
//   3. W=8,NCH=3: XOR on in_ch=3 -> err pulse 1 cycle, upd_cnt unchanged, out_data(ch3)=0.
//   4. LOAD ch1 0xA5, FINISH same next cycle, then XOR ch1 0xFF -> done=1, cont=0, in_ready=0,
//      st[1] stays 0xA5, upd_cnt=1.
//   5. CW=2: 5 accepted XORs -> upd_cnt 1,2,3,3,3 (saturation).
//   6. Assert rst asynchronously mid-stream in DONE -> outputs reset values before next edge;
//      in_ready=1, st=INIT, new XOR accepted on following edge.

Source files
------------

// File: rtl/stream_state_accum.sv
// Multi-channel running-state accumulator: per-channel XOR/ADD/LOAD updates from a
// command stream, terminated by a sticky FINISH command that only reset clears.
module stream_state_accum #(
  parameter int          W    = 1,
  parameter int          NCH  = 1,
  parameter logic [W-1:0] INIT = '0,
  parameter int          CW   = 8,
  localparam int         CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [1:0]     in_mode,
  input  logic [W-1:0]   in_data,
  output logic [W-1:0]   out_data,
  output logic           cont,
  output logic           done,
  output logic           err,
  output logic [CW-1:0]  upd_cnt
);

  typedef enum logic {S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_XOR = 2'b00, M_ADD = 2'b01, M_LOAD = 2'b10, M_FINISH = 2'b11} mode_t;

  state_t       state;
  mode_t        mode;
  logic [W-1:0] st [NCH];
  logic         ch_ok;
  logic         accept;

  assign mode   = mode_t'(in_mode);
  assign ch_ok  = (32'(in_ch) < NCH);
  assign accept = in_valid & in_ready;

  // Pre-update view of the addressed channel; out-of-range channels read as zero.
  always_comb begin
    out_data = '0;
    if (ch_ok) out_data = st[in_ch];
  end

  // NOTE: the state array is reset like any other register because INIT is
  // architectural state that consumers read straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      in_ready <= 1'b1;
      done     <= 1'b0;
      cont     <= 1'b1;
      err      <= 1'b0;
      upd_cnt  <= '0;
      for (int i = 0; i < NCH; i++) st[i] <= INIT;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (mode == M_FINISH) begin
          state    <= S_DONE;
          in_ready <= 1'b0;
          done     <= 1'b1;
          cont     <= 1'b0;
        end else if (!ch_ok) begin
          err <= 1'b1;
        end else begin
          case (mode)
            M_XOR:   st[in_ch] <= st[in_ch] ^ in_data;
            M_ADD:   st[in_ch] <= st[in_ch] + in_data;
            M_LOAD:  st[in_ch] <= in_data;
            default: ;
          endcase
          if (upd_cnt != '1) upd_cnt <= upd_cnt + CW'(1);
        end
      end
    end
  end

endmodule
